// File: rtl/grf_wb_port_pkg.sv
// Shared constants for the general register file and its writeback neighbours.
package grf_wb_port_pkg;

   // Register-address constants: hard-wired zero register and return-address register.
   localparam logic [4:0] R0 = 5'd0;
   localparam logic [4:0] RA = 5'd31;

   // Default geometry shared with the writeback mux and forwarding logic.
   localparam int unsigned GRF_AW = 5;
   localparam int unsigned GRF_DW = 32;

endpackage

// File: rtl/grf_wb_port_trace_reg.sv
// Write-trace record and committed-write counter, updated once per committed write.
module grf_trace_reg
   import grf_wb_port_pkg::*;
#(
   parameter int unsigned AW = GRF_AW,
   parameter int unsigned DW = GRF_DW
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_commit,
   input  logic [31:0]   i_pc,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   output logic          o_trace_valid,
   output logic [31:0]   o_trace_pc,
   output logic [AW-1:0] o_trace_addr,
   output logic [DW-1:0] o_trace_data,
   output logic [31:0]   o_wr_count
);

   logic          r_valid;
   logic [31:0]   r_pc;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic [31:0]   r_wr_count;

   // Capture the record on each commit; valid pulses only on commit edges, fields hold otherwise.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wr_count <= '0;
      end else begin
         r_valid <= i_commit;
         if (i_commit) begin
            r_pc       <= i_pc;
            r_addr     <= i_addr;
            r_data     <= i_data;
            r_wr_count <= r_wr_count + 32'd1; // wraps silently
         end
      end
   end

   assign o_trace_valid = r_valid;
   assign o_trace_pc    = r_pc;
   assign o_trace_addr  = r_addr;
   assign o_trace_data  = r_data;
   assign o_wr_count    = r_wr_count;

endmodule

// File: rtl/grf_wb_port.sv
// 2^AW x DW general register file fed by the W-stage writeback path, with two
// combinational D-stage read ports, optional W-to-D bypass and a write trace.
module grf_wb_port
   import grf_wb_port_pkg::*;
#(
   parameter int unsigned AW     = GRF_AW,
   parameter int unsigned DW     = GRF_DW,
   parameter bit          BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] a3,
   input  logic [DW-1:0] wd,
   input  logic [31:0]   pc_W,
   input  logic [AW-1:0] a1,
   input  logic [AW-1:0] a2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   output logic          trace_valid,
   output logic [31:0]   trace_pc,
   output logic [AW-1:0] trace_addr,
   output logic [DW-1:0] trace_data,
   output logic [31:0]   wr_count
);

   localparam int unsigned Depth = 2 ** AW;
   localparam logic [AW-1:0] ZeroAddr = AW'(R0);

   logic [DW-1:0] r_regs [Depth];
   logic          w_commit;
   logic [DW-1:0] w_rd1;
   logic [DW-1:0] w_rd2;

   // Writes to register 0 are dropped entirely: no array change, no trace, no count.
   assign w_commit = we && (a3 != ZeroAddr);

   // Register array; entry 0 is never written so it stays zero after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Depth; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[a3] <= wd;
      end
   end

   // Read ports: array lookup, then same-cycle bypass, then register-0 forcing.
   always_comb begin
      w_rd1 = r_regs[a1];
      w_rd2 = r_regs[a2];
      if (BYPASS && w_commit && (a3 == a1)) begin
         w_rd1 = wd;
      end
      if (BYPASS && w_commit && (a3 == a2)) begin
         w_rd2 = wd;
      end
      if (a1 == ZeroAddr) begin
         w_rd1 = '0;
      end
      if (a2 == ZeroAddr) begin
         w_rd2 = '0;
      end
   end

   assign rd1 = w_rd1;
   assign rd2 = w_rd2;

   grf_trace_reg #(
      .AW (AW),
      .DW (DW)
   ) u_trace (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_commit      (w_commit),
      .i_pc          (pc_W),
      .i_addr        (a3),
      .i_data        (wd),
      .o_trace_valid (trace_valid),
      .o_trace_pc    (trace_pc),
      .o_trace_addr  (trace_addr),
      .o_trace_data  (trace_data),
      .o_wr_count    (wr_count)
   );

endmodule

// File: tb/tb_grf_wb_port.sv
// Self-checking bench for grf_wb_port: a bypassing and a non-bypassing instance share inputs;
// expected trace records are queued when a commit is driven and popped after the edge.
module tb_grf_wb_port;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  addr;
      logic [31:0] data;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  a3, a1, a2;
   logic [31:0] wd, pc_W;
   logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
   logic        trace_valid, trace_valid_nb;
   logic [31:0] trace_pc, trace_pc_nb, trace_data, trace_data_nb, wr_count, wr_count_nb;
   logic [4:0]  trace_addr, trace_addr_nb;

   rec_t        sb_q[$];
   logic [31:0] m_regs[32];
   logic [31:0] m_cnt;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   grf_wb_port #(.AW(5), .DW(32), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .we(we), .a3(a3), .wd(wd), .pc_W(pc_W), .a1(a1), .a2(a2),
      .rd1(rd1), .rd2(rd2), .trace_valid(trace_valid), .trace_pc(trace_pc),
      .trace_addr(trace_addr), .trace_data(trace_data), .wr_count(wr_count)
   );

   grf_wb_port #(.AW(5), .DW(32), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .we(we), .a3(a3), .wd(wd), .pc_W(pc_W), .a1(a1), .a2(a2),
      .rd1(rd1_nb), .rd2(rd2_nb), .trace_valid(trace_valid_nb), .trace_pc(trace_pc_nb),
      .trace_addr(trace_addr_nb), .trace_data(trace_data_nb), .wr_count(wr_count_nb)
   );

   // Drive one W-stage cycle, queue the expected trace record, advance past the edge.
   task automatic step(input logic w, input logic [4:0] ad, input logic [31:0] d,
                       input logic [31:0] pc);
      we = w; a3 = ad; wd = d; pc_W = pc;
      if (w && ad != 5'd0) sb_q.push_back('{pc: pc, addr: ad, data: d});
      @(posedge clk); #1;
      if (w && ad != 5'd0) begin
         m_regs[ad] = d;
         m_cnt = m_cnt + 32'd1;
      end
      we = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      rec_t e;
      reset = 1'b1; we = 1'b0; a3 = 5'd0; wd = 32'd0; pc_W = 32'd0; a1 = 5'd5; a2 = 5'd5;
      model_reset();
      #1;
      checks++;
      if (rd1 !== 32'd0 || trace_valid !== 1'b0 || wr_count !== 32'd0 || trace_pc !== 32'd0
          || trace_addr !== 5'd0 || trace_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_initial: rd1=%h tv=%b cnt=%h pc=%h a=%0d d=%h, want all 0",
                  rd1, trace_valid, wr_count, trace_pc, trace_addr, trace_data);
      end
      @(negedge clk); reset = 1'b0;
      step(1'b1, 5'd5, 32'h1234, 32'h100);
      e = sb_q.pop_front();
      checks++;
      if (rd1 !== 32'h1234 || trace_valid !== 1'b1 || trace_data !== e.data
          || wr_count !== m_cnt) begin
         errors++;
         $display("FAIL reset_prewrite: rd1=%h tv=%b d=%h cnt=%h, want rd1=1234 tv=1 d=%h cnt=%h",
                  rd1, trace_valid, trace_data, wr_count, e.data, m_cnt);
      end
      // Assert reset between edges with a write pending; it must clear at once and drop the write.
      #2; we = 1'b1; a3 = 5'd6; wd = 32'hBAD0BAD0; reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (rd1 !== 32'd0 || trace_valid !== 1'b0 || wr_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_midrun: rd1=%h tv=%b cnt=%h, want 0 0 0",
                  rd1, trace_valid, wr_count);
      end
      @(posedge clk); @(negedge clk);
      reset = 1'b0; we = 1'b0; a1 = 5'd6;
      #1;
      checks++;
      if (rd1 !== 32'd0 || wr_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_lostwrite: rd1=%h cnt=%h, want 0 0", rd1, wr_count);
      end
   endtask

   task automatic test_basic();
      rec_t e;
      a1 = 5'd8; a2 = 5'd8;
      step(1'b1, 5'd8, 32'hDEADBEEF, 32'h0000_0200);
      e = sb_q.pop_front();
      checks++;
      if (rd1 !== 32'hDEADBEEF || rd1_nb !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_read: rd1=%h rd1_nb=%h, want deadbeef", rd1, rd1_nb);
      end
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== e.addr || trace_data !== e.data
          || trace_pc !== e.pc || wr_count !== m_cnt) begin
         errors++;
         $display("FAIL basic_trace: v=%b a=%0d d=%h pc=%h cnt=%h, want 1 %0d %h %h %h",
                  trace_valid, trace_addr, trace_data, trace_pc, wr_count,
                  e.addr, e.data, e.pc, m_cnt);
      end
   endtask

   task automatic test_reg0();
      logic [31:0] cnt0;
      step(1'b0, 5'd0, 32'd0, 32'd0); // quiet cycle so trace_valid is low beforehand
      cnt0 = m_cnt;
      a1 = 5'd0; a2 = 5'd0;
      we = 1'b1; a3 = 5'd0; wd = 32'hFFFFFFFF; #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
         errors++;
         $display("FAIL reg0_bypass: rd1=%h rd2=%h, want 0 0", rd1, rd2);
      end
      step(1'b1, 5'd0, 32'hFFFFFFFF, 32'h300);
      checks++;
      if (rd1 !== 32'd0 || trace_valid !== 1'b0 || wr_count !== cnt0) begin
         errors++;
         $display("FAIL reg0_write: rd1=%h tv=%b cnt=%h, want 0 0 %h",
                  rd1, trace_valid, wr_count, cnt0);
      end
   endtask

   task automatic test_bypass();
      rec_t e;
      a1 = 5'd9; a2 = 5'd9;
      step(1'b1, 5'd9, 32'd1, 32'h400);
      e = sb_q.pop_front();
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== e.addr) begin
         errors++;
         $display("FAIL bypass_setup: tv=%b a=%0d, want 1 %0d", trace_valid, trace_addr, e.addr);
      end
      we = 1'b1; a3 = 5'd9; wd = 32'h55; pc_W = 32'h404; #1;
      checks++;
      if (rd1 !== 32'h55 || rd2 !== 32'h55) begin
         errors++;
         $display("FAIL bypass_on: rd1=%h rd2=%h, want 55 55", rd1, rd2);
      end
      checks++;
      if (rd1_nb !== 32'd1 || rd2_nb !== 32'd1) begin
         errors++;
         $display("FAIL bypass_off_pre: rd1=%h rd2=%h, want 1 1", rd1_nb, rd2_nb);
      end
      step(1'b1, 5'd9, 32'h55, 32'h404);
      e = sb_q.pop_front();
      checks++;
      if (rd1_nb !== 32'h55 || rd2_nb !== 32'h55 || trace_data_nb !== e.data
          || trace_data !== e.data) begin
         errors++;
         $display("FAIL bypass_off_post: rd1=%h rd2=%h td=%h, want 55 55 %h",
                  rd1_nb, rd2_nb, trace_data_nb, e.data);
      end
   endtask

   task automatic test_back_to_back();
      rec_t        e;
      logic [31:0] cnt0;
      cnt0 = m_cnt;
      step(1'b1, 5'd31, 32'h3000, 32'h500);
      e = sb_q.pop_front();
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== e.addr || trace_data !== e.data
          || trace_pc !== e.pc) begin
         errors++;
         $display("FAIL b2b_first: v=%b a=%0d d=%h pc=%h, want 1 %0d %h %h",
                  trace_valid, trace_addr, trace_data, trace_pc, e.addr, e.data, e.pc);
      end
      step(1'b1, 5'd2, 32'd7, 32'h504);
      e = sb_q.pop_front();
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== e.addr || trace_data !== e.data
          || trace_pc !== e.pc) begin
         errors++;
         $display("FAIL b2b_second: v=%b a=%0d d=%h pc=%h, want 1 %0d %h %h",
                  trace_valid, trace_addr, trace_data, trace_pc, e.addr, e.data, e.pc);
      end
      step(1'b0, 5'd3, 32'h99, 32'h508);
      checks++;
      if (trace_valid !== 1'b0 || trace_addr !== 5'd2 || trace_data !== 32'd7
          || wr_count !== cnt0 + 32'd2) begin
         errors++;
         $display("FAIL b2b_after: v=%b a=%0d d=%h cnt=%h, want 0 2 7 %h",
                  trace_valid, trace_addr, trace_data, wr_count, cnt0 + 32'd2);
      end
      // Last write wins, each counted separately.
      step(1'b1, 5'd4, 32'h11, 32'h600);
      step(1'b1, 5'd4, 32'h22, 32'h604);
      void'(sb_q.pop_front());
      e = sb_q.pop_front();
      a1 = 5'd4; #1;
      checks++;
      if (rd1 !== 32'h22 || trace_data !== e.data || wr_count !== m_cnt) begin
         errors++;
         $display("FAIL last_wins: rd1=%h td=%h cnt=%h, want 22 %h %h",
                  rd1, trace_data, wr_count, e.data, m_cnt);
      end
   endtask

   task automatic test_readback();
      step(1'b0, 5'd0, 32'd0, 32'd0);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(31 - i); #1;
         checks++;
         if (rd1 !== m_regs[i] || rd2 !== m_regs[31 - i] || rd1_nb !== m_regs[i]) begin
            errors++;
            $display("FAIL readback[%0d]: rd1=%h rd2=%h rd1_nb=%h, want %h %h", i,
                     rd1, rd2, rd1_nb, m_regs[i], m_regs[31 - i]);
         end
      end
   endtask

   task automatic test_wrap();
      rec_t e;
      force dut.u_trace.r_wr_count = 32'hFFFFFFFF;
      #1;
      release dut.u_trace.r_wr_count;
      m_cnt = 32'hFFFFFFFF;
      step(1'b1, 5'd3, 32'hA5, 32'h700);
      e = sb_q.pop_front();
      checks++;
      if (wr_count !== 32'd0 || trace_valid !== 1'b1 || trace_addr !== e.addr) begin
         errors++;
         $display("FAIL wrap: cnt=%h tv=%b a=%0d, want 0 1 %0d",
                  wr_count, trace_valid, trace_addr, e.addr);
      end
      step(1'b0, 5'd0, 32'd0, 32'd0);
      checks++;
      if (wr_count !== m_cnt || trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_hold: cnt=%h tv=%b, want %h 0", wr_count, trace_valid, m_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reg0();
      test_bypass();
      test_back_to_back();
      test_readback();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grf_wb_port.md
Name: grf_wb_port

Overview:
- General register file (GRF) at the consuming end of the W-stage writeback path.
- Accepts the selected write address and data from the writeback mux, commits them to a 32x32 register array and serves two combinational D-stage read ports.
- Internal W-to-D bypass applies when read and write target the same register in the same cycle.
- Emits a registered one-cycle write-trace record and a committed-write counter for the bench and debug.

Parameters:
- AW, 5, register address width; array depth is 2^AW.
- DW, 32, data width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the old value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  1  W-stage register write enable.
- a3  in  AW  write address (writeback mux address output).
- wd  in  DW  write data (writeback mux data output).
- pc_W  in  32  PC of the instruction in W; used for the trace only.
- a1  in  AW  read address, port 1 (rs).
- a2  in  AW  read address, port 2 (rt).
- rd1  out  DW  read data, port 1.
- rd2  out  DW  read data, port 2.
- trace_valid  out  1  pulses for one cycle after each committed write.
- trace_pc  out  32  PC of the committed write.
- trace_addr  out  AW  register written.
- trace_data  out  DW  value written.
- wr_count  out  32  number of committed writes since reset.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset asserts immediately, with no clock needed:
  - all 2^AW registers go to 0;
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, wr_count=0.
- Reset asserted mid-write: the write is lost. The first edge after reset deassertion with we=1 commits normally.
- Commit condition: the commit occurs at the rising edge where we=1 and a3!=0; at that edge array[a3]<=wd.
- Register 0:
  - reads of address 0 always return 0;
  - we=1 with a3=0 is dropped: no array change, no trace, no count.
- Reads are combinational: rd1=array[a1], rd2=array[a2], with register-0 forcing applied.
- Bypass (BYPASS=1):
  - if we=1, a3!=0 and a3==a1, then rd1=wd in the same cycle; likewise rd2 when a3==a2;
  - both ports may bypass simultaneously.
  - With BYPASS=0, rd shows the new value only from the cycle after the commit.
- Trace (latency 1 edge):
  - at each commit edge, trace_pc<=pc_W, trace_addr<=a3, trace_data<=wd and trace_valid<=1;
  - at any non-commit edge trace_valid<=0, and the other trace fields hold their last value.
  - Back-to-back commits keep trace_valid high, with the fields updating every cycle.
- Counter: wr_count increments by 1 at each commit edge and wraps from 0xFFFFFFFF to 0 with no flag.
- Repeated writes to the same register: the last one wins. Each write is traced and counted separately.
- Inputs a1/a2/a3 are always in range, since the depth equals 2^AW; no out-of-range case exists.

Decomposition:
- const.v gains:
  - `R0 (5'd0) and `RA (5'd31) register-address constants;
  - `GRF_AW and `GRF_DW defaults, shared with the writeback mux and the forwarding logic.
- One sub-module is natural: grf_trace_reg, holding the trace fields and wr_count. It takes commit, pc_W, a3 and wd, and keeps the trace/counter logic out of the array code.
- No other package types are needed.

Test Plan:
1. Reset mid-run: write 0x1234 to $5, then assert reset between edges -> rd(a1=5)=0, trace_valid=0 and wr_count=0 immediately, before the next edge.
2. Basic write/read: we=1, a3=8, wd=0xDEADBEEF at edge N -> from cycle N onward rd1(a1=8)=0xDEADBEEF; in cycle N+1 trace_valid=1 with trace_addr=8, trace_data=0xDEADBEEF and trace_pc=pc_W, and wr_count=1.
3. Register 0: we=1, a3=0, wd=0xFFFFFFFF -> rd1(a1=0)=0, trace_valid stays 0, wr_count unchanged.
4. Bypass: with $9 holding 1, drive we=1, a3=9, wd=0x55, a1=a2=9 in the same cycle -> rd1=rd2=0x55 before the edge. Repeat with BYPASS=0 -> rd1=rd2=1 before the edge and 0x55 after it.
5. Back-to-back: commits to $31=0x3000 and then $2=7 on consecutive edges -> trace_valid high for 2 cycles with addresses 31 then 2, then low; wr_count +2.
6. Counter wrap: force wr_count=0xFFFFFFFF, then commit one write -> wr_count=0 and trace_valid=1.
